// File: rtl/impulse_avg_recorder.sv
// Impulse-response recorder: fires an impulse, skips a programmable delay, records
// IMPULSE_LENGTH samples per pass and averages 2**LOG2_AVG passes via an accumulator RAM.
module impulse_avg_recorder #(
    parameter int DATA_WIDTH     = 16,
    parameter int IMPULSE_LENGTH = 48000,
    parameter int ADDR_WIDTH     = 16,
    parameter int LOG2_AVG       = 2,
    parameter int RD_LATENCY     = 2,
    localparam int ACC_WIDTH     = DATA_WIDTH + LOG2_AVG
) (
    input  logic                         audio_clk,
    input  logic                         rst_in_n,
    input  logic                         audio_trigger,
    input  logic                         start_in,
    input  logic                         abort_in,
    input  logic [15:0]                  delay_length,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    output logic                         impulse_req,
    input  logic                         impulse_done,
    output logic [ADDR_WIDTH-1:0]        acc_addr,
    output logic                         acc_wr_en,
    output logic signed [ACC_WIDTH-1:0]  acc_wr_data,
    input  logic signed [ACC_WIDTH-1:0]  acc_rd_data,
    output logic [ADDR_WIDTH-1:0]        res_addr,
    output logic                         res_wr_en,
    output logic signed [DATA_WIDTH-1:0] res_wr_data,
    output logic                         busy,
    output logic                         impulse_recorded,
    output logic [LOG2_AVG-1:0]          pass_count
);

    localparam int WAIT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(IMPULSE_LENGTH - 1);
    localparam logic [LOG2_AVG-1:0]   LAST_PASS  = '1;
    localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_IMP,
        DELAY,
        RECORD,
        RD_WAIT,
        DONE
    } state_t;

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        index;
    logic [15:0]                  delay_cnt;
    logic [15:0]                  delay_len;
    logic [WAIT_W-1:0]            wait_cnt;
    logic signed [DATA_WIDTH-1:0] sample;

    logic                         last_pass;
    logic signed [ACC_WIDTH-1:0]  sample_ext;
    logic signed [ACC_WIDTH-1:0]  prev_acc;
    logic signed [ACC_WIDTH-1:0]  sum;

    // The first pass starts from zero so stale RAM contents never leak into a new run.
    always_comb begin
        last_pass  = (pass_count == LAST_PASS);
        sample_ext = {{LOG2_AVG{sample[DATA_WIDTH-1]}}, sample};
        prev_acc   = (pass_count == '0) ? '0 : acc_rd_data;
        sum        = prev_acc + sample_ext;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state            <= IDLE;
            index            <= '0;
            delay_cnt        <= '0;
            delay_len        <= '0;
            wait_cnt         <= '0;
            sample           <= '0;
            pass_count       <= '0;
            impulse_req      <= 1'b0;
            impulse_recorded <= 1'b0;
            acc_addr         <= '0;
            acc_wr_en        <= 1'b0;
            acc_wr_data      <= '0;
            res_addr         <= '0;
            res_wr_en        <= 1'b0;
            res_wr_data      <= '0;
        end else begin
            impulse_req <= 1'b0;
            acc_wr_en   <= 1'b0;
            res_wr_en   <= 1'b0;

            if (abort_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            state            <= FIRE;
                            impulse_req      <= 1'b1;
                            pass_count       <= '0;
                            index            <= '0;
                            impulse_recorded <= 1'b0;
                        end
                    end
                    FIRE: begin
                        state <= WAIT_IMP;
                    end
                    WAIT_IMP: begin
                        if (impulse_done) begin
                            delay_len <= delay_length;
                            delay_cnt <= '0;
                            state     <= (delay_length == 16'd0) ? RECORD : DELAY;
                        end
                    end
                    DELAY: begin
                        if (audio_trigger) begin
                            if (delay_cnt == delay_len - 16'd1) begin
                                state <= RECORD;
                            end else begin
                                delay_cnt <= delay_cnt + 16'd1;
                            end
                        end
                    end
                    RECORD: begin
                        if (audio_trigger) begin
                            sample   <= audio_in;
                            acc_addr <= index;
                            wait_cnt <= '0;
                            state    <= RD_WAIT;
                        end
                    end
                    // acc_addr stays on index through the write cycle, so the strobe
                    // lands on the same location that was read.
                    RD_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            acc_wr_en   <= 1'b1;
                            acc_wr_data <= sum;
                            if (last_pass) begin
                                res_wr_en   <= 1'b1;
                                res_wr_data <= DATA_WIDTH'(sum >>> LOG2_AVG);
                                res_addr    <= index;
                            end
                            if (index == LAST_INDEX) begin
                                index <= '0;
                                if (last_pass) begin
                                    state <= DONE;
                                end else begin
                                    pass_count  <= pass_count + 1'b1;
                                    impulse_req <= 1'b1;
                                    state       <= FIRE;
                                end
                            end else begin
                                index <= index + 1'b1;
                                state <= RECORD;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        impulse_recorded <= 1'b1;
                        state            <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
